aes_inv_key_sched_128: RTL and testbench



---
 rtl/aes_inv_key_sched_128.sv | 160 ++++++++++++++++
 tb/tb_aes_inv_key_sched_128.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched_128.sv
// AES-128 key schedule for the decryption datapath: expands the cipher key forward to round 10,
// then streams round keys 10..0 over valid/ready, regenerating each from its successor.

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as required)
  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

  assign w_x2   = gf_mul(i_a, i_a);
  assign w_x3   = gf_mul(w_x2, i_a);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x15  = gf_mul(w_x12, w_x3);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign w_inv  = gf_mul(w_x252, w_x2);

  assign o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

module aes_inv_key_sched_128 #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_key_sched_128 supports NR == 10 only");
  end

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

  state_e       r_state, w_state_d;
  logic [127:0] r_rk, w_rk_d;
  logic [3:0]   r_round, w_round_d;
  logic [7:0]   r_rcon, w_rcon_d;

  logic [31:0]  w_a0, w_a1, w_a2, w_a3;
  logic [31:0]  w_p1, w_p2, w_p3;
  logic [31:0]  w_sb_in, w_rot, w_sub, w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_xtime, w_inv_xtime;

  assign {w_a0, w_a1, w_a2, w_a3} = r_rk;

  assign w_p3 = w_a3 ^ w_a2;
  assign w_p2 = w_a2 ^ w_a1;
  assign w_p1 = w_a1 ^ w_a0;

  // The four S-boxes serve w3 going forward and p3 coming back
  assign w_sb_in = (r_state == StOut) ? w_p3 : w_a3;
  assign w_rot   = {w_sb_in[23:0], w_sb_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .i_a (w_rot[8*i +: 8]),
      .o_s (w_sub[8*i +: 8])
    );
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = w_a0 ^ w_t;
  assign w_n1 = w_a1 ^ w_n0;
  assign w_n2 = w_a2 ^ w_n1;
  assign w_n3 = w_a3 ^ w_n2;

  assign w_xtime     = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_inv_xtime = r_rcon[0] ? (((r_rcon ^ 8'h1b) >> 1) | 8'h80) : (r_rcon >> 1);

  always_comb begin
    w_state_d = r_state;
    w_rk_d    = r_rk;
    w_round_d = r_round;
    w_rcon_d  = r_rcon;
    unique case (r_state)
      StIdle: begin
        if (key_load) begin
          w_state_d = StFwd;
          w_rk_d    = key_in;
          w_round_d = 4'd0;
          w_rcon_d  = 8'h01;
        end
      end
      StFwd: begin
        w_rk_d    = {w_n0, w_n1, w_n2, w_n3};
        w_round_d = r_round + 4'd1;
        // rcon stays at the round-10 value so the reverse walk starts from it
        if (r_round == LastRound - 4'd1) begin
          w_state_d = StOut;
        end else begin
          w_rcon_d = w_xtime;
        end
      end
      StOut: begin
        if (rk_ready) begin
          if (r_round == 4'd0) begin
            w_state_d = StIdle;
          end else begin
            w_rk_d    = {w_a0 ^ w_t, w_p1, w_p2, w_p3};
            w_round_d = r_round - 4'd1;
            w_rcon_d  = w_inv_xtime;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_rk    <= '0;
      r_round <= 4'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_d;
      r_rk    <= w_rk_d;
      r_round <= w_round_d;
      r_rcon  <= w_rcon_d;
    end
  end

  assign busy     = (r_state != StIdle);
  assign rk_valid = (r_state == StOut);
  assign rk_last  = (r_state == StOut) && (r_round == 4'd0);
  assign rk_out   = r_rk;
  assign rk_round = r_round;

endmodule

// File: tb/tb_aes_inv_key_sched_128.sv
// Scoreboard bench for aes_inv_key_sched_128: expected beats come from a FIPS-197 style
// word expansion with an S-box built by brute-force field inversion.

module tb_aes_inv_key_sched_128;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  always #5 clk = ~clk;

  aes_inv_key_sched_128 #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_load (key_load),
    .busy     (busy),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_last  (rk_last)
  );

  typedef struct {
    int           rnd;
    logic [127:0] rk;
  } beat_t;

  beat_t        exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           beats  = 0;
  logic [127:0] seen_rk  [0:10];
  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tab [1:10];
  logic [127:0] rk_tab   [0:10];

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      end
      sbox_tab[x] = s;
    end
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]],
               sbox_tab[tmp[7:0]]} ^ {rcon_tab[i / 4], 24'h000000};
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic push_seq(input logic [127:0] key);
    beat_t b;
    build_model(key);
    for (int r = 10; r >= 0; r--) begin
      b.rnd = r;
      b.rk  = rk_tab[r];
      exp_q.push_back(b);
    end
  endtask

  // ---------------- monitor ----------------
  logic         prev_stall = 1'b0;
  logic [127:0] prev_rk;
  logic [3:0]   prev_rnd;

  always @(negedge clk) begin
    beat_t e;
    if (!rst && prev_stall) begin
      check_int("stall_valid", int'(rk_valid), 1);
      check("stall_rk", rk_out, prev_rk);
      check_int("stall_round", int'(rk_round), int'(prev_rnd));
    end
    if (!rst && rk_valid && rk_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got round %0d with no beat expected", rk_round);
      end else begin
        e = exp_q.pop_front();
        check_int("beat_round", int'(rk_round), e.rnd);
        check("beat_rk", rk_out, e.rk);
        check_int("beat_last", int'(rk_last), (e.rnd == 0) ? 1 : 0);
        if (rk_round <= 4'd10) seen_rk[rk_round] = rk_out;
      end
    end
    prev_stall = !rst && rk_valid && !rk_ready;
    prev_rk    = rk_out;
    prev_rnd   = rk_round;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    push_seq(key);
    tick();
    key_load = 1'b0;
  endtask

  task automatic latency(input string name);
    int n;
    n = 0;
    while (!rk_valid && n < 40) begin
      tick();
      n++;
    end
    check_int(name, n, 10);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check_int(name, (n < 300) ? 1 : 0, 1);
    check_int({name, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic clear_seen();
    for (int r = 0; r <= 10; r++) seen_rk[r] = '1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           b0;
    int           n;
    logic         stalled;
    logic [127:0] ka;
    logic [127:0] kb;

    rst      = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    build_sbox();
    repeat (3) tick();
    check("rst_rk_out", rk_out, '0);
    check_int("rst_round", int'(rk_round), 0);
    check_int("rst_valid", int'(rk_valid), 0);
    check_int("rst_last", int'(rk_last), 0);
    check_int("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // FIPS-197 key at full rate
    clear_seen();
    rk_ready = 1'b1;
    b0 = beats;
    do_load(KeyFips);
    check_int("fips_busy", int'(busy), 1);
    latency("fips_latency");
    for (int i = 0; i < 11; i++) begin
      check_int("fips_consec_valid", int'(rk_valid), 1);
      tick();
    end
    check_int("fips_done_busy", int'(busy), 0);
    check_int("fips_done_valid", int'(rk_valid), 0);
    check_int("fips_beats", beats - b0, 11);
    check("fips_rk_hold", rk_out, KeyFips);
    check("fips_r10", seen_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r9", seen_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_r1", seen_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r0", seen_rk[0], KeyFips);
    tick();

    // Random backpressure with a 5-cycle stall at round 6
    b0 = beats;
    stalled = 1'b0;
    do_load(KeyFips);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      if (!stalled && rk_valid && rk_round == 4'd6) begin
        rk_ready = 1'b0;
        repeat (5) begin
          tick();
          check_int("bp_hold_round", int'(rk_round), 6);
        end
        stalled = 1'b1;
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    rk_ready = 1'b1;
    check_int("bp_timeout", (n < 400) ? 1 : 0, 1);
    check_int("bp_stall_seen", int'(stalled), 1);
    check_int("bp_beats", beats - b0, 11);
    tick();

    // All-zero key
    clear_seen();
    do_load('0);
    wait_idle("zero_done");
    check("zero_r10", seen_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("zero_r1", seen_rk[1], 128'h62636363626363636263636362636363);
    tick();

    // key_load pulses while busy must be ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    b0 = beats;
    do_load(ka);
    repeat (3) tick();
    key_in   = kb;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n = 0;
    while (!(rk_valid && rk_round == 4'd5) && n < 40) begin
      tick();
      n++;
    end
    check_int("ign_reach_r5", (n < 40) ? 1 : 0, 1);
    key_in   = kb;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_idle("ign_done");
    check_int("ign_beats", beats - b0, 11);
    tick();

    // Reset at round 7, then a full sequence
    ka = {$urandom, $urandom, $urandom, $urandom};
    do_load(ka);
    n = 0;
    while (!(rk_valid && rk_round == 4'd7) && n < 40) begin
      tick();
      n++;
    end
    check_int("rst_reach_r7", (n < 40) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_rk_out", rk_out, '0);
    check_int("mid_rst_round", int'(rk_round), 0);
    check_int("mid_rst_valid", int'(rk_valid), 0);
    check_int("mid_rst_last", int'(rk_last), 0);
    check_int("mid_rst_busy", int'(busy), 0);
    repeat (3) begin
      tick();
      check_int("mid_rst_quiet", int'(rk_valid), 0);
    end
    kb = {$urandom, $urandom, $urandom, $urandom};
    b0 = beats;
    do_load(kb);
    latency("post_rst_latency");
    wait_idle("post_rst_done");
    check_int("post_rst_beats", beats - b0, 11);
    tick();

    // key_load held high: one sequence, one idle cycle, next sequence
    ka = {$urandom, $urandom, $urandom, $urandom};
    key_in   = ka;
    key_load = 1'b1;
    push_seq(ka);
    tick();
    b0 = beats;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check_int("b2b_first_done", (n < 100) ? 1 : 0, 1);
    check_int("b2b_first_beats", beats - b0, 11);
    check_int("b2b_idle_busy", int'(busy), 0);
    push_seq(ka);
    tick();
    check_int("b2b_one_idle", int'(busy), 1);
    key_load = 1'b0;
    b0 = beats;
    latency("b2b_fwd_cycles");
    wait_idle("b2b_second_done");
    check_int("b2b_second_beats", beats - b0, 11);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
